xc20xx_clb_cfg_loader: RTL



---
 rtl/xc20xx_cfg_pkg.sv | 29 ++
 rtl/xc20xx_cfg_shifter.sv | 39 +++
 rtl/xc20xx_clb_cfg_loader.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/xc20xx_cfg_pkg.sv
// Shared types and constants for the XC20XX CLB configuration loader.
// Optional parity build: define XC20XX_CFG_PARITY_EN.
package xc20xx_cfg_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LENGTH,
        S_FSTART,
        S_FDATA,
        S_FPAR,
        S_FSTOP,
        S_CHECK,
        S_DONE,
        S_ERR
    } cfg_state_e;

    localparam logic [3:0]  PREAMBLE  = 4'b0010;
    localparam int unsigned LEN_W     = 24;
    localparam int unsigned STOP_BITS = 3;

    // CLB configuration word field layout
    localparam int unsigned F_INIT_LSB = 14;
    localparam int unsigned G_INIT_LSB = 6;
    localparam int unsigned MUX_FG_BIT = 5;
    localparam int unsigned MODE_BIT   = 4;
    localparam int unsigned XSEL_LSB   = 2;
    localparam int unsigned YSEL_LSB   = 0;

endpackage

// File: rtl/xc20xx_cfg_shifter.sv
// Enable-gated MSB-first shift register with a bit counter that flags
// the final bit of a W-bit field; the counter wraps itself for the next field.
module xc20xx_cfg_shifter
    import xc20xx_cfg_pkg::*;
#(
    parameter int unsigned W = 22
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         din_i,
    output logic [W-1:0] data_o,
    output logic         last_o
);

    localparam int unsigned CNT_W = $clog2(W);

    logic [W-1:0]     data_q;
    logic [CNT_W-1:0] cnt_q;

    assign data_o = data_q;
    assign last_o = (cnt_q == CNT_W'(W - 1));

    // Shift one bit in per enabled cycle and track position within the field
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (en_i) begin
            data_q <= {data_q[W-2:0], din_i};
            cnt_q  <= last_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/xc20xx_clb_cfg_loader.sv
// Serial bitstream parser: preamble, 24-bit length, NUM_CLB framed config
// words, then a length check. Optional per-frame even parity bit when
// XC20XX_CFG_PARITY_EN is defined.
module xc20xx_clb_cfg_loader
    import xc20xx_cfg_pkg::*;
#(
    parameter int unsigned NUM_CLB = 4,
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned CFG_W   = 22
) (
    input  logic              K,
    input  logic              RST_N,
    input  logic              DIN,
    input  logic              DIN_VALID,
    output logic              CFG_WE,
    output logic [ADDR_W-1:0] CFG_ADDR,
    output logic [CFG_W-1:0]  CFG_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    cfg_state_e        state_q;
    logic [3:0]        hist_q;
    logic [LEN_W-1:0]  bitcnt_q;
    logic [1:0]        stop_q;
    logic [ADDR_W-1:0] idx_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CFG_W-1:0]  data_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic [LEN_W-1:0]  len_word;
    logic              len_last;
    logic [CFG_W-1:0]  frm_word;
    logic              frm_last;
    logic              in_frame;
    logic              sh_clr;

    assign in_frame = (state_q == S_FSTART) || (state_q == S_FDATA) ||
                      (state_q == S_FPAR)   || (state_q == S_FSTOP);
    assign sh_clr   = (state_q == S_IDLE);

    xc20xx_cfg_shifter #(.W(LEN_W)) u_len_sh (
        .clk_i   (K),
        .rst_n_i (RST_N),
        .clr_i   (sh_clr),
        .en_i    (DIN_VALID && (state_q == S_LENGTH)),
        .din_i   (DIN),
        .data_o  (len_word),
        .last_o  (len_last)
    );

    xc20xx_cfg_shifter #(.W(CFG_W)) u_frm_sh (
        .clk_i   (K),
        .rst_n_i (RST_N),
        .clr_i   (sh_clr),
        .en_i    (DIN_VALID && (state_q == S_FDATA)),
        .din_i   (DIN),
        .data_o  (frm_word),
        .last_o  (frm_last)
    );

    assign CFG_WE   = we_q;
    assign CFG_ADDR = addr_q;
    assign CFG_DATA = data_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;

    // Main parser FSM; all outputs registered, only valid bits advance it
    always_ff @(posedge K or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            hist_q   <= '0;
            bitcnt_q <= '0;
            stop_q   <= '0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (DIN_VALID && in_frame && (bitcnt_q != '1)) begin
                bitcnt_q <= bitcnt_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (DIN_VALID) begin
                        hist_q <= {hist_q[2:0], DIN};
                        if ({hist_q, DIN} == {1'b1, PREAMBLE}) begin
                            state_q <= S_LENGTH;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_LENGTH: begin
                    if (DIN_VALID && len_last) begin
                        state_q <= S_FSTART;
                    end
                end
                S_FSTART: begin
                    if (DIN_VALID) begin
                        if (DIN) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_FDATA;
                        end
                    end
                end
                S_FDATA: begin
                    if (DIN_VALID && frm_last) begin
                        stop_q <= '0;
`ifdef XC20XX_CFG_PARITY_EN
                        state_q <= S_FPAR;
`else
                        state_q <= S_FSTOP;
`endif
                    end
                end
                S_FPAR: begin
`ifdef XC20XX_CFG_PARITY_EN
                    if (DIN_VALID) begin
                        if ((^frm_word) ^ DIN) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_FSTOP;
                        end
                    end
`else
                    state_q <= S_IDLE;
`endif
                end
                S_FSTOP: begin
                    if (DIN_VALID) begin
                        if (!DIN) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (stop_q == 2'(STOP_BITS - 1)) begin
                            we_q   <= 1'b1;
                            addr_q <= idx_q;
                            data_q <= frm_word;
                            idx_q  <= idx_q + 1'b1;
                            if (idx_q == ADDR_W'(NUM_CLB - 1)) begin
                                state_q <= S_CHECK;
                            end else begin
                                state_q <= S_FSTART;
                            end
                        end else begin
                            stop_q <= stop_q + 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    busy_q <= 1'b0;
                    if (len_word == bitcnt_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
